// File: rtl/matrix_bram_arb_pkg.sv
// Shared types for the matrix BRAM read-port arbiter.
// Includes the requester limit and the owner-id width helper.
package matrix_bram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SINGLE,
    ARB_LOCKED
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first-set: first set bit of req at or after ptr,
// wrapping modulo N. Pure combinational.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         found,
  output logic [2:0]   idx,
  output logic [N-1:0] onehot
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [3:0]     sum;

  assign dbl = {req, req};
  assign rot = dbl[N-1:0] >> ptr | dbl[2*N-1:N] << (N - int'(ptr));

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    sum    = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + 4'(k);
        if (sum >= 4'(N))
          sum = sum - 4'(N);
        idx    = sum[2:0];
        onehot = N'(1) << sum[2:0];
      end
    end
  end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// Round-robin arbiter for the shared matrix BRAM read port, with
// locked bursts and a latency-matched tag pipe for read-data routing.
module matrix_bram_arbiter
  import matrix_bram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_en,
  input  logic [DATA_WIDTH-1:0]         bram_data,
  output logic [2:0]                    owner_id,
  output logic                          busy
);

  localparam int IDW = id_width(NUM_REQ);

  arb_state_t         state;
  logic [2:0]         owner;
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] gnt_q;

  logic               pick_found;
  logic [2:0]         pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [2:0]         nxt_ptr;
  logic               hold;

  logic [READ_LATENCY-1:0] tag_v;
  logic [IDW-1:0]          tag_id [READ_LATENCY];

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  assign nxt_ptr = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0
                                                 : pick_idx + 3'd1;
  assign hold = (state == ARB_LOCKED) && |(gnt_q & lock);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      gnt_q  <= '0;
    end else if (!hold) begin
      if (pick_found) begin
        gnt_q  <= pick_oh;
        owner  <= pick_idx;
        rr_ptr <= nxt_ptr;
        state  <= |(pick_oh & lock) ? ARB_LOCKED : ARB_SINGLE;
      end else begin
        gnt_q <= '0;
        state <= ARB_IDLE;
      end
    end
  end

  // Tags follow the read through the BRAM so routing ignores later grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int s = 0; s < READ_LATENCY; s++)
        tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= bram_en;
      tag_id[0] <= owner[IDW-1:0];
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    bram_addr = '0;
    rd_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i])
        bram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd_valid[i] = tag_v[READ_LATENCY-1] &&
                    (tag_id[READ_LATENCY-1] == IDW'(i));
    end
  end

  assign gnt      = gnt_q;
  assign bram_en  = |(gnt_q & req);
  assign busy     = |gnt_q;
  assign owner_id = owner;
  assign rd_data  = bram_data;

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// Scoreboard bench for matrix_bram_arbiter: directed scenarios then
// random traffic against a behavioural arbiter and BRAM model.
module tb_matrix_bram_arbiter;

  localparam int N   = 4;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic [AW-1:0] addr [N];
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt, rd_valid;
  logic [DW-1:0] rd_data, bram_data;
  logic [AW-1:0] bram_addr;
  logic          bram_en, busy;
  logic [2:0]    owner_id;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < N; i++)
      req_addr[i*AW +: AW] = addr[i];
  end

  matrix_bram_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .req_addr(req_addr), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_data(bram_data), .owner_id(owner_id), .busy(busy)
  );

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // BRAM model: keeps returning data regardless of arbiter reset
  logic [DW-1:0] bq [LAT];
  always @(posedge clk) begin
    bq[0] <= bram_en ? f(bram_addr) : 32'hDEAD_BEEF;
    for (int s = 1; s < LAT; s++)
      bq[s] <= bq[s-1];
  end
  assign bram_data = bq[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];
  int pulses [N];

  // Reference arbiter: mode 0 idle, 1 single grant, 2 locked
  int m_mode = 0;
  int m_owner = 0;
  int m_ptr = 0;
  logic [N-1:0] last_beat;

  function automatic logic [N-1:0] m_gnt();
    return (m_mode != 0) ? N'(1) << m_owner : '0;
  endfunction

  task automatic model_step();
    int w;
    w = -1;
    if (rst) begin
      m_mode = 0; m_owner = 0; m_ptr = 0;
    end else if (!(m_mode == 2 && lock[m_owner])) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w < 0) m_mode = 0;
      else begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_mode  = lock[w] ? 2 : 1;
      end
    end
  endtask

  task automatic tick();
    logic e;
    exp_t keep[$];
    @(negedge clk);
    last_beat = '0;
    if (cyc > 0) begin
      e = (m_mode != 0) && req[m_owner];
      chk("gnt", gnt, m_gnt());
      chk("busy", busy, m_mode != 0);
      chk("bram_en", bram_en, e);
      chk("bram_addr", bram_addr, (m_mode != 0) ? addr[m_owner] : '0);
      if (m_mode != 0) chk("owner_id", owner_id, m_owner);
      if (rst) begin
        foreach (sb[j]) if (sb[j].due <= cyc) keep.push_back(sb[j]);
        sb = keep;
      end else if (e) begin
        last_beat[m_owner] = 1'b1;
        sb.push_back('{m_owner, f(addr[m_owner]), cyc + LAT});
      end
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_gnt(input logic [N-1:0] want);
    int n = 0;
    while (gnt !== want && n < 40) begin tick(); n++; end
    chk("gnt_wait", gnt, want);
  endtask

  task automatic wait_beat(input int i);
    int n = 0;
    do begin tick(); n++; end while (!last_beat[i] && n < 40);
    chk("beat_wait", last_beat[i], 1'b1);
  endtask

  task automatic drain();
    req = '0; lock = '0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < N; i++) if (rd_valid[i] === 1'b1) pulses[i]++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
          chk("rd_valid", rd_valid, N'(1) << sb[0].id);
          chk("rd_data", rd_data, sb[0].data);
          void'(sb.pop_front());
        end else begin
          chk("rd_valid_idle", rd_valid, '0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt [N];
    int n;
    for (int i = 0; i < N; i++) begin addr[i] = '0; pulses[i] = 0; end

    rst = 1'b1; req = '1;
    repeat (3) tick();
    chk("rst_gnt", gnt, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", bram_en, 1'b0);
    chk("rst_rdv", rd_valid, '0);
    rst = 1'b0;
    tick();
    chk("release_gnt", gnt, 4'b0001);
    n = 0;
    while (req != '0 && n < 20) begin tick(); req &= ~last_beat; n++; end
    chk("release_drain", req, '0);
    drain();

    pulses[2] = 0;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      addr[2] = AW'(16 + k);
      wait_beat(2);
    end
    drain();
    chk("single_pulses", pulses[2], 4);

    req = 4'b1011;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    repeat (6) begin
      tick();
      for (int i = 0; i < N; i++) if (gnt[i]) cnt[i]++;
    end
    chk("rr_cnt0", cnt[0], 2);
    chk("rr_cnt1", cnt[1], 2);
    chk("rr_cnt2", cnt[2], 0);
    chk("rr_cnt3", cnt[3], 2);
    drain();

    addr[0] = 14'h055; addr[1] = 14'h100;
    req = 4'b0011; lock = 4'b0010;
    wait_gnt(4'b0010);
    for (int k = 0; k < 8; k++) begin
      addr[1] = AW'(14'h100 + k);
      if (k == 7) lock[1] = 1'b0;
      chk("burst_gnt", gnt, 4'b0010);
      tick();
    end
    req[1] = 1'b0;
    chk("burst_end_gnt", gnt, 4'b0001);
    drain();

    addr[3] = 14'h200;
    req = 4'b1000; lock = 4'b1000;
    wait_gnt(4'b1000);
    tick();
    addr[3] = 14'h201;
    tick();
    addr[3] = 14'h202;
    req[3] = 1'b0;
    repeat (2) tick();
    chk("pause_gnt", gnt, 4'b1000);
    req[3] = 1'b1;
    tick();
    chk("resume_beat", last_beat, 4'b1000);
    lock = '0;
    tick();
    drain();

    addr[0] = 14'h300; addr[2] = 14'h302;
    req = 4'b0101;
    n = 0;
    do begin tick(); n++; end while (last_beat == '0 && n < 40);
    req &= ~last_beat;
    tick();
    chk("second_beat", last_beat, 4'b0101 & ~(4'b0101 & ~req) | 4'b0);
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain();

    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_beat[i]) begin
          if ($urandom_range(1) == 1) addr[i] = AW'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2) == 0) begin
          req[i]  = 1'b1;
          addr[i] = AW'($urandom);
        end
        if ($urandom_range(7) == 0) lock[i] = ~lock[i];
      end
      rst = ($urandom_range(199) == 0);
    end
    rst = 1'b0;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
